uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the SoC debug/console UART, the receive counterpart of the existing `uart_tx`. It runs entirely on the system clock with an internal 16x oversampling tick, deserialises 8N1 frames (8E1 when parity is compiled in) from `uart_rxd`, and presents each byte to the bus-side register logic through a hold-until-read handshake with error flags.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 115200, line baud rate
- `clk_i`  in  1  system clock; all logic on the rising edge
- `sys_rst_n`  in  1  reset; one clock, synchronous, active-low
- `uart_rxd`  in  1  asynchronous serial input; idles high
- `uartRen`  in  1  one-cycle read strobe; consumes the held byte
- `uartRData`  out  8  received byte
- `rx_valid`  out  1  byte held and unread
- `rx_busy`  out  1  frame in progress (state ≠ IDLE)
- `frame_err`  out  1  stop bit of the held byte sampled low
- `parity_err`  out  1  parity mismatch on the held byte (constant 0 without the macro)
- `overrun`  out  1  sticky; a byte completed while `rx_valid` was 1

## Operation
- Input passes through a 2-FF synchroniser; all decisions use the synchronised bit `rxd_s`.
- Tick generator: `DIV = (CLK_FREQ + 8*BAUD) / (16*BAUD)` (rounded); `DIV >= 2` is required. The counter runs 0..DIV-1, and `tick` pulses for one clock at DIV-1. The counter is held at 0 in IDLE, so the phase aligns to the start edge.
- Sample counter `scnt` is 4 bits and counts ticks within a bit; bit counter `bcnt` is 3 bits.
- States and transitions:
  - IDLE: `rxd_s==0` -> START, counters cleared.
  - START: when `scnt` reaches 7 (mid-bit), re-check `rxd_s`. If it is 1, this is a false start -> IDLE with no flags. If it is 0, clear `scnt` -> DATA.
  - DATA: every 16 ticks, sample `rxd_s` into the shift register, LSB first. After bit 7 -> PARITY if the macro is defined, else STOP.
  - PARITY: sample at 16 ticks and compare against even parity of the 8 data bits -> STOP.
  - STOP: sample at 16 ticks.
    - Load `uartRData` and set `rx_valid`.
    - Set `frame_err` = !sample and `parity_err` = mismatch.
    - If `rx_valid` was already 1, set `overrun`; the new byte replaces the old one.
    - If the sample is 1 -> IDLE. If it is 0 -> BREAK.
  - BREAK: wait for `rxd_s==1` -> IDLE. No further bytes are produced while the line is held low.
- Read handshake: `uartRen` while `rx_valid` clears `rx_valid`, `frame_err`, `parity_err` and `overrun`. `uartRen` with `rx_valid==0` has no effect.
- Simultaneous byte completion and `uartRen` in the same clock: the new byte wins. `rx_valid` stays 1, error flags take the new byte's values, and `overrun` is not set.

## Timing
- Reset values: `uartRData`=0, `rx_valid`=0, `rx_busy`=0, all error flags 0, state IDLE, synchroniser FFs 1.
- Reset mid-frame: the partial byte is discarded. After reset the receiver waits in IDLE for a fresh falling edge.
- Synchroniser latency is 2 clocks. Start detect to IDLE->START is 1 clock after `rxd_s` falls.
- `rx_valid` rises on the clock after the stop-bit mid-sample, i.e. about 9.5 bit times after the line falling edge (10.5 bit times with parity).
- `uartRData` is stable for the whole time `rx_valid` is 1, except on overrun replacement.
- `rx_busy` is 1 from START entry through BREAK exit.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state is present, the frame is 8E1, and `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: the frame is 8N1, `parity_err` is tied 0, and no PARITY state logic is generated.

## Structure
- Shared `uart_pkg` (include file) holds:
  - state encodings `UART_RX_IDLE/START/DATA/PARITY/STOP/BREAK` (3 bits)
  - `UART_OVERSAMPLE`=16 and `UART_MIDSAMPLE`=7
  - data width 8
- These constants are shared with `uart_tx`.
- One sub-module, `uart_rx_tick`, contains the DIV counter with synchronous clear and outputs `tick`. The FSM, shifter and handshake stay in `uart_rx`.

## Test plan
Bench configuration for all scenarios: `CLK_FREQ`=7_372_800, `BAUD`=115200, giving DIV=4 and 64 clocks per bit.
- Send 0xA5 in 8N1 -> `rx_valid` rises, `uartRData`=0xA5, no flags; `uartRen` -> `rx_valid`=0.
- Drive a 20-clock low glitch on an idle line -> returns to IDLE, `rx_valid` stays 0, no flags.
- Send 0x3C with the stop bit low, then hold the line high -> `uartRData`=0x3C, `frame_err`=1; the FSM passes through BREAK and the next frame 0x11 is received cleanly.
- Send 0x01 then 0x02 without reading -> `uartRData`=0x02, `overrun`=1; `uartRen` clears all flags.
- Assert reset at data bit 4 of 0xFF, then send 0x55 -> `rx_valid`=0 through reset, then 0x55 is received with no flags.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 -> `parity_err`=1; send it with parity bit 1 -> `parity_err`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: receiver state encodings, oversampling ratio,
// mid-bit sample index, data width and the baud divisor helper.
package uart_pkg;

   localparam int UART_DW         = 8;
   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_MIDSAMPLE  = 7;

   typedef enum logic [2:0] {
      UART_RX_IDLE   = 3'd0,
      UART_RX_START  = 3'd1,
      UART_RX_DATA   = 3'd2,
      UART_RX_PARITY = 3'd3,
      UART_RX_STOP   = 3'd4,
      UART_RX_BREAK  = 3'd5
   } uart_rx_state_e;

   // Clocks per oversample tick, rounded to nearest.
   function automatic int uart_div(input int clk_hz, input int baud);
      return (clk_hz + 8 * baud) / (16 * baud);
   endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: counts 0..DIV-1, pulses tick_o at DIV-1.
// Ports: clk_i, rst_ni (sync, active-low), clr_i (hold at 0), tick_o.
module uart_rx_tick #(
   parameter int DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TOP = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || cnt_q == TOP) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == TOP);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, 8N1 (8E1 with UART_RX_PARITY_EN),
// hold-until-read byte buffer with frame/parity/overrun flags.
// Ports: clk_i, sys_rst_n (sync, active-low), uart_rxd (async line),
//   uartRen (read strobe), uartRData, rx_valid, rx_busy, frame_err,
//   parity_err, overrun.
// Requires uart_div(CLK_FREQ, BAUD) >= 2.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic               clk_i,
   input  logic               sys_rst_n,
   input  logic               uart_rxd,
   input  logic               uartRen,
   output logic [UART_DW-1:0] uartRData,
   output logic               rx_valid,
   output logic               rx_busy,
   output logic               frame_err,
   output logic               parity_err,
   output logic               overrun
);

   localparam int DIV = uart_div(CLK_FREQ, BAUD);
   localparam logic [3:0] MID  = 4'(UART_MIDSAMPLE);
   localparam logic [3:0] LAST = 4'(UART_OVERSAMPLE - 1);
   localparam logic [2:0] BLST = 3'(UART_DW - 1);

   uart_rx_state_e state_q, state_d;

   logic rxd_meta_q, rxd_s_q;
   logic [3:0] scnt_q;
   logic [2:0] bcnt_q;
   logic [UART_DW-1:0] shift_q;
   logic [UART_DW-1:0] data_q;
   logic valid_q, ferr_q, ovr_q;

   logic tick, tick_clr;
   logic mid_hit, bit_hit;
   logic to_data, do_shift, do_stop;

   // Two-flop synchroniser; idles high so reset never looks like a start.
   always_ff @(posedge clk_i) begin
      if (!sys_rst_n) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
      end else begin
         rxd_meta_q <= uart_rxd;
         rxd_s_q    <= rxd_meta_q;
      end
   end

   uart_rx_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk_i  (clk_i),
      .rst_ni (sys_rst_n),
      .clr_i  (tick_clr),
      .tick_o (tick)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (!sys_rst_n) begin
         state_q <= UART_RX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         UART_RX_IDLE: begin
            if (!rxd_s_q) state_d = UART_RX_START;
         end
         UART_RX_START: begin
            if (mid_hit) begin
               state_d = rxd_s_q ? UART_RX_IDLE : UART_RX_DATA;
            end
         end
         UART_RX_DATA: begin
            if (do_shift && bcnt_q == BLST) begin
`ifdef UART_RX_PARITY_EN
               state_d = UART_RX_PARITY;
`else
               state_d = UART_RX_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         UART_RX_PARITY: begin
            if (bit_hit) state_d = UART_RX_STOP;
         end
`endif
         UART_RX_STOP: begin
            if (bit_hit) begin
               state_d = rxd_s_q ? UART_RX_IDLE : UART_RX_BREAK;
            end
         end
         UART_RX_BREAK: begin
            if (rxd_s_q) state_d = UART_RX_IDLE;
         end
         default: state_d = UART_RX_IDLE;
      endcase
   end

   // Output / strobe logic
   always_comb begin
      rx_busy  = (state_q != UART_RX_IDLE);
      tick_clr = 1'b0;
      mid_hit  = tick && (scnt_q == MID);
      bit_hit  = tick && (scnt_q == LAST);
      to_data  = 1'b0;
      do_shift = 1'b0;
      do_stop  = 1'b0;
      case (state_q)
         UART_RX_IDLE:  tick_clr = 1'b1;
         UART_RX_START: to_data  = mid_hit && !rxd_s_q;
         UART_RX_DATA:  do_shift = bit_hit;
         UART_RX_STOP:  do_stop  = bit_hit;
         default: ;
      endcase
   end

   // Sample and bit counters; scnt wraps every 16 ticks by width.
   always_ff @(posedge clk_i) begin
      if (!sys_rst_n) begin
         scnt_q <= '0;
         bcnt_q <= '0;
      end else begin
         if (tick_clr || to_data) begin
            scnt_q <= '0;
         end else if (tick) begin
            scnt_q <= scnt_q + 4'd1;
         end
         if (tick_clr) begin
            bcnt_q <= '0;
         end else if (do_shift) begin
            bcnt_q <= bcnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!sys_rst_n) begin
         shift_q <= '0;
      end else if (do_shift) begin
         shift_q <= {rxd_s_q, shift_q[UART_DW-1:1]};
      end
   end

`ifdef UART_RX_PARITY_EN
   logic do_par;
   logic pbad_q, perr_q;

   assign do_par = (state_q == UART_RX_PARITY) && bit_hit;

   // Even parity: the parity bit equals the XOR of the data bits.
   always_ff @(posedge clk_i) begin
      if (!sys_rst_n) begin
         pbad_q <= 1'b0;
      end else if (do_par) begin
         pbad_q <= rxd_s_q ^ (^shift_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!sys_rst_n) begin
         perr_q <= 1'b0;
      end else if (do_stop) begin
         perr_q <= pbad_q;
      end else if (uartRen && valid_q) begin
         perr_q <= 1'b0;
      end
   end

   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   // Holding buffer. A completing byte beats a same-cycle read, and the
   // read then only suppresses the overrun it would otherwise cause.
   always_ff @(posedge clk_i) begin
      if (!sys_rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (do_stop) begin
         data_q  <= shift_q;
         valid_q <= 1'b1;
         ferr_q  <= !rxd_s_q;
         ovr_q   <= valid_q && !uartRen;
      end else if (uartRen && valid_q) begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end
   end

   assign uartRData = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames
// compared against a byte-level receive model.
module tb_uart_rx;

   localparam int CLK_FREQ = 7_372_800;
   localparam int BAUD     = 115200;
   localparam int BITCLK   = 64;
`ifdef UART_RX_PARITY_EN
   localparam int  NBITS  = 11;
   localparam bit  PAR_EN = 1'b1;
`else
   localparam int  NBITS  = 10;
   localparam bit  PAR_EN = 1'b0;
`endif
   // rx_valid expected about (NBITS - 0.5) bit times after the falling edge
   localparam int LAT_NOM = (2 * NBITS - 1) * BITCLK / 2;
   localparam int LAT_LO  = LAT_NOM - 8;
   localparam int LAT_HI  = LAT_NOM + 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rxd;
   logic       ren;
   logic [7:0] rdata;
   logic       rx_valid, rx_busy, frame_err, parity_err, overrun;

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) dut (
      .clk_i      (clk),
      .sys_rst_n  (rst_n),
      .uart_rxd   (rxd),
      .uartRen    (ren),
      .uartRData  (rdata),
      .rx_valid   (rx_valid),
      .rx_busy    (rx_busy),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc;
   int   rise_at;
   logic prev_v;
   logic saw_busy;

   logic [7:0] m_data;
   logic       m_valid, m_ferr, m_perr, m_ovr;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc++;
         if (rx_valid && !prev_v && rise_at < 0) rise_at = cyc;
         prev_v = rx_valid;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_reset();
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_perr  = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] d, input logic stop,
                             input logic pflip);
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = d;
      m_ferr  = !stop;
      m_perr  = PAR_EN ? pflip : 1'b0;
   endtask

   task automatic do_read();
      ren = 1'b1;
      wait_clk(1);
      ren = 1'b0;
      if (m_valid) begin
         m_valid = 1'b0;
         m_ferr  = 1'b0;
         m_perr  = 1'b0;
         m_ovr   = 1'b0;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, " data"}, rdata, m_data);
      check({tag, " valid"}, rx_valid, m_valid);
      check({tag, " frame_err"}, frame_err, m_ferr);
      check({tag, " parity_err"}, parity_err, m_perr);
      check({tag, " overrun"}, overrun, m_ovr);
      check({tag, " busy"}, rx_busy, 1'b0);
   endtask

   // Drives one frame, then one idle (high) bit time.
   task automatic send_frame(input string tag, input logic [7:0] d,
                             input logic stop, input logic pflip);
      logic [NBITS-1:0] fr;
      logic             was_valid;
      fr        = '1;
      fr[0]     = 1'b0;
      fr[8:1]   = d;
`ifdef UART_RX_PARITY_EN
      fr[9]     = (^d) ^ pflip;
`endif
      fr[NBITS-1] = stop;
      cyc       = 0;
      rise_at   = -1;
      prev_v    = rx_valid;
      was_valid = rx_valid;
      for (int i = 0; i < NBITS; i++) begin
         rxd = fr[i];
         wait_clk(BITCLK);
      end
      saw_busy = rx_busy;
      rxd = 1'b1;
      wait_clk(BITCLK);
      if (!was_valid) begin
         check({tag, " latency"},
               (rise_at >= LAT_LO && rise_at <= LAT_HI), 1'b1);
      end
      model_byte(d, stop, pflip);
   endtask

   initial begin
      logic [7:0] d;
      logic       st, pf;

      rst_n = 1'b0;
      rxd   = 1'b1;
      ren   = 1'b0;
      cyc   = 0;
      rise_at = -1;
      prev_v  = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(5);
      check_outputs("reset");

      send_frame("a5", 8'hA5, 1'b1, 1'b0);
      check_outputs("a5");
      do_read();
      check("a5 read valid", rx_valid, 1'b0);

      rxd = 1'b0;
      wait_clk(10);
      check("glitch busy", rx_busy, 1'b1);
      wait_clk(10);
      rxd = 1'b1;
      wait_clk(100);
      check_outputs("glitch");

      send_frame("3c", 8'h3C, 1'b0, 1'b0);
      check("3c break busy", saw_busy, 1'b1);
      check_outputs("3c");
      do_read();
      send_frame("11", 8'h11, 1'b1, 1'b0);
      check_outputs("11");
      do_read();

      send_frame("01", 8'h01, 1'b1, 1'b0);
      send_frame("02", 8'h02, 1'b1, 1'b0);
      check_outputs("ovr");
      do_read();
      check_outputs("ovr read");

      rxd = 1'b0;
      wait_clk(BITCLK);
      rxd = 1'b1;
      wait_clk(4 * BITCLK + BITCLK / 2);
      rst_n = 1'b0;
      wait_clk(1);
      rst_n = 1'b1;
      model_reset();
      check("mid reset valid", rx_valid, 1'b0);
      wait_clk(6 * BITCLK);
      check_outputs("mid reset");
      send_frame("55", 8'h55, 1'b1, 1'b0);
      check_outputs("55");
      do_read();

`ifdef UART_RX_PARITY_EN
      send_frame("par bad", 8'h07, 1'b1, 1'b1);
      check_outputs("par bad");
      do_read();
      send_frame("par ok", 8'h07, 1'b1, 1'b0);
      check_outputs("par ok");
      do_read();
`endif

      for (int k = 0; k < 10; k++) begin
         d  = 8'($urandom);
         st = ($urandom_range(0, 3) != 0);
         pf = PAR_EN ? 1'($urandom_range(0, 1)) : 1'b0;
         send_frame("rnd", d, st, pf);
         check_outputs("rnd");
         if ($urandom_range(0, 1) == 1) do_read();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
